// File: rtl/fpga_receiver.sv
// rtl/fpga_receiver.sv - 4-phase handshake serial byte receiver with registered acknowledge
//
// Purpose:
//   Receives one byte per frame from a remote transmitter over an asynchronous
//   4-phase req/ack handshake. The remote side raises req_in once to start a frame.
//   It then sends eight data bits, LSB first, each qualified by its own req_in
//   handshake. It closes the frame with a fin_in handshake. A completed frame
//   updates rx_data and pulses rx_valid. An early fin or a ninth bit aborts the
//   frame and pulses rx_err. rx_data is left untouched on an abort.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high reset
//   req_in   in   request level from the transmitter (asynchronous)
//   data_in  in   serial data bit, stable while req_in is high (asynchronous)
//   fin_in   in   end-of-frame request level (asynchronous)
//   ack_out  out  registered acknowledge back to the transmitter
//   rx_data  out  last completed byte, held until the next completed frame
//   rx_valid out  one-cycle pulse when rx_data is updated
//   rx_err   out  one-cycle pulse when a frame is aborted
//   busy     out  high whenever the receiver is not idle
//
// Build option:
//   FPGA_RX_TIMEOUT_EN - when defined, a 16-bit watchdog returns the receiver to
//   idle (with an rx_err pulse) once it has sat in one busy state for 0xFFFF
//   cycles. When undefined, the receiver waits indefinitely in every state.

module fpga_receiver (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_in,
    input  logic       data_in,
    input  logic       fin_in,
    output logic       ack_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START_ACK,
        WAIT_BIT,
        BIT_ACK,
        WAIT_FIN,
        FIN_ACK,
        DONE
    } rxState_t;

    rxState_t   state;
    rxState_t   stateNext;

    logic [1:0] reqSync;
    logic [1:0] finSync;
    logic [1:0] dataSync;
    logic       req_s;
    logic       fin_s;
    logic       data_s;

    logic [3:0] bitCount;
    logic [7:0] shiftReg;
    logic       abortFrame;
    logic       captureBit;

`ifdef FPGA_RX_TIMEOUT_EN
    logic [15:0] watchdog;
`endif

    // Two-flop synchronizers. data_in passes through the same depth as req_in.
    // data_s is therefore aligned with the req_s edge that qualifies it.
    always_ff @(posedge clk) begin
        if (reset) begin
            reqSync  <= 2'b00;
            finSync  <= 2'b00;
            dataSync <= 2'b00;
        end else begin
            reqSync  <= {reqSync[0], req_in};
            finSync  <= {finSync[0], fin_in};
            dataSync <= {dataSync[0], data_in};
        end
    end

    assign req_s  = reqSync[1];
    assign fin_s  = finSync[1];
    assign data_s = dataSync[1];

    // Next-state decode. The registered outputs below are derived from stateNext.
    // ack_out and busy are therefore valid in the same cycle the state is entered.
    always_comb begin
        stateNext  = state;
        abortFrame = 1'b0;
        captureBit = 1'b0;
        case (state)
            IDLE: begin
                // A lone fin_s in idle is stale and is ignored.
                if (req_s) stateNext = START_ACK;
            end
            START_ACK: begin
                if (!req_s) stateNext = WAIT_BIT;
            end
            WAIT_BIT: begin
                // An early fin wins over a simultaneous bit request.
                if (fin_s) begin
                    stateNext  = IDLE;
                    abortFrame = 1'b1;
                end else if (req_s) begin
                    stateNext  = BIT_ACK;
                    captureBit = 1'b1;
                end
            end
            BIT_ACK: begin
                if (!req_s) stateNext = (bitCount == 4'd8) ? WAIT_FIN : WAIT_BIT;
            end
            WAIT_FIN: begin
                if (fin_s) begin
                    stateNext = FIN_ACK;
                end else if (req_s) begin
                    // A ninth data bit means the frame is too long.
                    stateNext  = IDLE;
                    abortFrame = 1'b1;
                end
            end
            FIN_ACK: begin
                if (!fin_s) stateNext = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
`ifdef FPGA_RX_TIMEOUT_EN
        if ((state != IDLE) && (watchdog == 16'hFFFF)) begin
            stateNext  = IDLE;
            abortFrame = 1'b1;
            captureBit = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bitCount <= 4'd0;
            shiftReg <= 8'h00;
            rx_data  <= 8'h00;
            ack_out  <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            busy     <= 1'b0;
`ifdef FPGA_RX_TIMEOUT_EN
            watchdog <= 16'h0000;
`endif
        end else begin
            state    <= stateNext;
            ack_out  <= (stateNext == START_ACK) || (stateNext == BIT_ACK) ||
                        (stateNext == FIN_ACK);
            busy     <= (stateNext != IDLE);
            rx_err   <= abortFrame;
            rx_valid <= 1'b0;

            if ((state == IDLE) && (stateNext == START_ACK)) begin
                bitCount <= 4'd0;
            end

            // Shift right with the new bit entering at the top.
            // After eight bits, the first bit received sits in bit 0.
            if (captureBit) begin
                shiftReg <= {data_s, shiftReg[7:1]};
                if (bitCount != 4'd8) begin
                    bitCount <= bitCount + 4'd1;
                end
            end

            if ((state == FIN_ACK) && (stateNext == DONE)) begin
                rx_data  <= shiftReg;
                rx_valid <= 1'b1;
            end

`ifdef FPGA_RX_TIMEOUT_EN
            // The watchdog restarts on every state change.
            // It only advances while the receiver is busy.
            if (stateNext != state) begin
                watchdog <= 16'h0000;
            end else if (state != IDLE) begin
                watchdog <= watchdog + 16'h0001;
            end
`endif
        end
    end

endmodule

// File: doc/fpga_receiver.md
FPGA_RECEIVER -- requirements
Module: fpga_receiver

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 req_in  input  1  request level from remote transmitter; asynchronous to clk.
REQ-004 data_in  input  1  serial data bit, LSB first; stable while req_in high; asynchronous.
REQ-005 fin_in  input  1  end-of-frame request level from remote transmitter; asynchronous.
REQ-006 ack_out  output  1  registered acknowledge to remote transmitter.
REQ-007 rx_data  output  8  last completed byte; held until next completed frame.
REQ-008 rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-009 rx_err  output  1  one-cycle pulse when a frame is aborted.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 req_in, fin_in and data_in SHALL each pass through a 2-flop synchronizer; the FSM SHALL use only the synchronized copies (req_s, fin_s, data_s).
REQ-012 States: IDLE, START_ACK, WAIT_BIT, BIT_ACK, WAIT_FIN, FIN_ACK, DONE.
REQ-013 IDLE: req_s=1 -> START_ACK; fin_s=1 alone -> stay IDLE (ignored); else stay.
REQ-014 START_ACK: ack_out=1; bit counter cleared to 0; req_s=0 -> WAIT_BIT.
REQ-015 WAIT_BIT: fin_s=1 -> IDLE with rx_err pulse (fin has priority over simultaneous req); req_s=1 -> BIT_ACK, capture data_s into shift register, counter+1.
REQ-016 Shift register SHALL shift right with data_s entering bit 7, so the first bit received ends in bit 0.
REQ-017 BIT_ACK: ack_out=1; req_s=0 -> WAIT_FIN if counter=8, else WAIT_BIT.
REQ-018 Counter is 4 bits, counts 0..8, never wraps within a frame.
REQ-019 WAIT_FIN: fin_s=1 -> FIN_ACK; req_s=1 (ninth bit) -> IDLE with rx_err pulse.
REQ-020 FIN_ACK: ack_out=1; fin_s=0 -> DONE.
REQ-021 DONE: rx_data <= shift register, rx_valid=1 for exactly one cycle; unconditional -> IDLE.
REQ-022 ack_out SHALL be registered: req_in rising before edge N yields ack_out=1 after edge N+2; ack_out falls 3 edges after req_in falls (4-phase handshake).
REQ-023 rx_data SHALL NOT change on aborted frames.

Reset
REQ-024 On reset=1 at a clock edge: state=IDLE, synchronizers=0, counter=0, shift register=0, rx_data=0x00, ack_out=0, rx_valid=0, rx_err=0, busy=0.
REQ-025 Reset mid-frame SHALL discard the partial byte without an rx_err pulse; rx_data SHALL be cleared to 0x00.

Configuration
REQ-026 Macro FPGA_RX_TIMEOUT_EN defined: a 16-bit watchdog counter SHALL clear on every state change and increment each cycle while busy; at 0xFFFF the FSM SHALL go to IDLE with an rx_err pulse and ack_out=0.
REQ-027 FPGA_RX_TIMEOUT_EN undefined: no watchdog logic; the FSM SHALL wait indefinitely in any state.

Verification
REQ-028 Send start + bits of 0xA5 LSB first + fin with full 4-phase handshake -> rx_data=0xA5, rx_valid one pulse, rx_err=0.
REQ-029 Raise req_in at edge N from IDLE -> ack_out=1 after edge N+2; drop req_in -> ack_out=0 three edges later.
REQ-030 Start + 5 bits then fin_in -> rx_err one pulse, state IDLE, rx_data unchanged from previous 0xA5.
REQ-031 Start + 8 bits then a ninth req_in -> rx_err one pulse, IDLE, rx_data unchanged.
REQ-032 Assert reset after 4 bits of 0x3C -> all outputs 0 next cycle, no rx_err; following full frame 0x3C -> rx_data=0x3C.
REQ-033 With FPGA_RX_TIMEOUT_EN: start then hold req_in low for 65536 cycles -> rx_err pulse, busy=0; without macro -> busy stays 1.
